// File: rtl/wb_regfile_pkg.sv
// Shared constants, types and helpers for the write-back stage and register file.
// Register addresses are 5 bits wide and register 0 is hardwired to zero.
package wb_regfile_pkg;

  localparam int NREGS    = 32;
  localparam int DATA_W   = 32;
  localparam int PEND_W   = 2;
  localparam int ADDR_W   = 5;
  localparam int PEND_MAX = (1 << PEND_W) - 1;

  localparam logic [ADDR_W-1:0] REG0 = 5'd0;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [PEND_W-1:0] pend_t;

  // 1 when an enabled event targets register r; events aimed at r0 never count.
  function automatic int hit(input logic en, input addr_t dst, input addr_t r);
    return (en && dst != REG0 && dst == r) ? 1 : 0;
  endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// Bundles the MEM/WB inputs, the ID read/issue ports and the stage outputs.
// The DUT side uses the slave modport; the driver side uses master.
interface wb_regfile_if;
  import wb_regfile_pkg::*;

  data_t ALUResult;
  data_t mem_read;
  addr_t regdst;
  logic  memtoreg;
  logic  regwrite;

  addr_t rs_addr;
  addr_t rt_addr;
  logic  use_rs;
  logic  use_rt;
  data_t rs_data;
  data_t rt_data;

  logic  issue_valid;
  logic  issue_regwrite;
  addr_t issue_dst;
  logic  kill_valid;
  addr_t kill_dst;

  logic  stall;
  data_t wb_data;
  logic  sb_error;

  modport slave (
    input  ALUResult, mem_read, regdst, memtoreg, regwrite,
    input  rs_addr, rt_addr, use_rs, use_rt,
    input  issue_valid, issue_regwrite, issue_dst, kill_valid, kill_dst,
    output rs_data, rt_data, stall, wb_data, sb_error
  );

  modport master (
    output ALUResult, mem_read, regdst, memtoreg, regwrite,
    output rs_addr, rt_addr, use_rs, use_rt,
    output issue_valid, issue_regwrite, issue_dst, kill_valid, kill_dst,
    input  rs_data, rt_data, stall, wb_data, sb_error
  );

endinterface

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one saturating counter per register, bumped at issue
// and dropped at write-back or squash, plus a sticky underflow/overflow flag.
module wb_scoreboard
  import wb_regfile_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  issue_valid_i,
  input  logic  issue_regwrite_i,
  input  addr_t issue_dst_i,
  input  logic  stall_i,
  input  logic  we_i,
  input  addr_t wb_dst_i,
  input  logic  kill_valid_i,
  input  addr_t kill_dst_i,
  input  addr_t rs_addr_i,
  input  addr_t rt_addr_i,
  output logic  rs_pend_o,
  output logic  rt_pend_o,
  output logic  sb_error_o
);

  pend_t pend_q [NREGS];
  pend_t pend_d [NREGS];
  logic  sb_error_q;
  logic  sb_error_d;
  logic  inc;

  assign inc        = issue_valid_i && !stall_i && issue_regwrite_i;
  assign sb_error_o = sb_error_q;

  // The writer retiring this cycle is already covered by the bypass, so it
  // no longer counts against a reader; a negative result still reads as pending.
  function automatic int eff(input addr_t r);
    return int'(pend_q[r]) - hit(we_i, wb_dst_i, r) - hit(kill_valid_i, kill_dst_i, r);
  endfunction

  always_comb begin
    rs_pend_o = (eff(rs_addr_i) != 0);
    rt_pend_o = (eff(rt_addr_i) != 0);
  end

  always_comb begin
    int net;
    net        = 0;
    sb_error_d = sb_error_q;
    for (int r = 0; r < NREGS; r++) begin
      pend_d[r] = pend_q[r];
    end
    pend_d[0] = '0;
    for (int r = 1; r < NREGS; r++) begin
      net = int'(pend_q[r])
          + hit(inc, issue_dst_i, addr_t'(r))
          - hit(we_i, wb_dst_i, addr_t'(r))
          - hit(kill_valid_i, kill_dst_i, addr_t'(r));
      if (net < 0) begin
        pend_d[r]  = '0;
        sb_error_d = 1'b1;
      end else if (net > PEND_MAX) begin
        pend_d[r]  = pend_t'(PEND_MAX);
        sb_error_d = 1'b1;
      end else begin
        pend_d[r] = pend_t'(net);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        pend_q[r] <= '0;
      end
      sb_error_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        pend_q[r] <= pend_d[r];
      end
      sb_error_q <= sb_error_d;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage and architectural register file with two combinational read
// ports, same-cycle write-through bypass, and a RAW-hazard stall from the scoreboard.
module wb_regfile
  import wb_regfile_pkg::*;
(
  input logic         clk,
  input logic         reset,
  wb_regfile_if.slave bus
);

  data_t regs_q [NREGS];
  data_t wb_sel;
  logic  we;
  logic  rs_pend;
  logic  rt_pend;

  // Write-through: a value committing this edge is visible to readers now.
  function automatic data_t rd(input addr_t a);
    if (a == REG0) begin
      return '0;
    end else if (we && bus.regdst == a) begin
      return wb_sel;
    end else begin
      return regs_q[a];
    end
  endfunction

  always_comb begin
    wb_sel      = bus.memtoreg ? bus.mem_read : bus.ALUResult;
    we          = bus.regwrite && (bus.regdst != REG0);
    bus.wb_data = wb_sel;
    bus.rs_data = rd(bus.rs_addr);
    bus.rt_data = rd(bus.rt_addr);
    bus.stall   = bus.issue_valid && ((bus.use_rs && rs_pend) || (bus.use_rt && rt_pend));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
    end else if (we) begin
      regs_q[bus.regdst] <= wb_sel;
    end
  end

  wb_scoreboard u_scoreboard (
    .clk              (clk),
    .reset            (reset),
    .issue_valid_i    (bus.issue_valid),
    .issue_regwrite_i (bus.issue_regwrite),
    .issue_dst_i      (bus.issue_dst),
    .stall_i          (bus.stall),
    .we_i             (we),
    .wb_dst_i         (bus.regdst),
    .kill_valid_i     (bus.kill_valid),
    .kill_dst_i       (bus.kill_dst),
    .rs_addr_i        (bus.rs_addr),
    .rt_addr_i        (bus.rt_addr),
    .rs_pend_o        (rs_pend),
    .rt_pend_o        (rt_pend),
    .sb_error_o       (bus.sb_error)
  );

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus a randomized run
// compared against an array/integer model of the register file and scoreboard.
module tb_wb_regfile;
  import wb_regfile_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wb_regfile_if bus ();

  wb_regfile dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  data_t mRegs [NREGS];
  int    mPend [NREGS];
  bit    mErr;

  function automatic bit m_we();
    return bus.regwrite && bus.regdst != 0;
  endfunction

  function automatic data_t m_wb();
    return bus.memtoreg ? bus.mem_read : bus.ALUResult;
  endfunction

  function automatic data_t m_read(input addr_t a);
    if (a == 0) return '0;
    if (m_we() && bus.regdst == a) return m_wb();
    return mRegs[a];
  endfunction

  function automatic int m_eff(input addr_t a);
    int e;
    e = mPend[a];
    if (m_we() && bus.regdst == a) e = e - 1;
    if (bus.kill_valid && bus.kill_dst != 0 && bus.kill_dst == a) e = e - 1;
    return e;
  endfunction

  function automatic bit m_stall();
    return bus.issue_valid && ((bus.use_rs && m_eff(bus.rs_addr) != 0) ||
                               (bus.use_rt && m_eff(bus.rt_addr) != 0));
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NREGS; r++) begin
      mRegs[r] = '0;
      mPend[r] = 0;
    end
    mErr = 1'b0;
  endtask

  // Applies one clock edge worth of architectural effect, using the inputs held at the edge.
  task automatic model_commit();
    bit st;
    int n;
    if (reset) begin
      model_reset();
      return;
    end
    st = m_stall();
    for (int r = 1; r < NREGS; r++) begin
      n = mPend[r];
      if (bus.issue_valid && !st && bus.issue_regwrite && bus.issue_dst == r) n = n + 1;
      if (m_we() && bus.regdst == r) n = n - 1;
      if (bus.kill_valid && bus.kill_dst == r) n = n - 1;
      if (n < 0) begin
        n = 0;
        mErr = 1'b1;
      end else if (n > PEND_MAX) begin
        n = PEND_MAX;
        mErr = 1'b1;
      end
      mPend[r] = n;
    end
    if (m_we()) mRegs[bus.regdst] = m_wb();
  endtask

  task automatic set_idle();
    bus.ALUResult      = '0;
    bus.mem_read       = '0;
    bus.regdst         = '0;
    bus.memtoreg       = 1'b0;
    bus.regwrite       = 1'b0;
    bus.rs_addr        = '0;
    bus.rt_addr        = '0;
    bus.use_rs         = 1'b0;
    bus.use_rt         = 1'b0;
    bus.issue_valid    = 1'b0;
    bus.issue_regwrite = 1'b0;
    bus.issue_dst      = '0;
    bus.kill_valid     = 1'b0;
    bus.kill_dst       = '0;
  endtask

  task automatic advance();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic issue_writer(input addr_t dst);
    set_idle();
    bus.issue_valid    = 1'b1;
    bus.issue_regwrite = 1'b1;
    bus.issue_dst      = dst;
    advance();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_idle();
    model_reset();
    repeat (2) advance();
    reset = 1'b0;
    bus.issue_valid = 1'b1;
    bus.use_rs      = 1'b1;
    bus.use_rt      = 1'b1;
    for (int i = 0; i < NREGS; i++) begin
      bus.rs_addr = addr_t'(i);
      bus.rt_addr = addr_t'(NREGS - 1 - i);
      #1;
      compared++;
      if (bus.rs_data !== 32'h0) begin
        mismatched++;
        $display("FAIL reset_rs[%0d]: got %h expected 00000000", i, bus.rs_data);
      end
      compared++;
      if (bus.rt_data !== 32'h0) begin
        mismatched++;
        $display("FAIL reset_rt[%0d]: got %h expected 00000000", NREGS - 1 - i, bus.rt_data);
      end
      compared++;
      if (bus.stall !== 1'b0) begin
        mismatched++;
        $display("FAIL reset_stall[%0d]: got %b expected 0", i, bus.stall);
      end
    end
    compared++;
    if (bus.sb_error !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_sb_error: got %b expected 0", bus.sb_error);
    end
    set_idle();
    @(negedge clk);
  endtask

  task automatic test_bypass();
    issue_writer(5'd5);
    set_idle();
    bus.regwrite  = 1'b1;
    bus.regdst    = 5'd5;
    bus.memtoreg  = 1'b0;
    bus.ALUResult = 32'hDEADBEEF;
    bus.mem_read  = 32'h0BAD0BAD;
    bus.rs_addr   = 5'd5;
    bus.rt_addr   = 5'd6;
    #1;
    compared++;
    if (bus.rs_data !== 32'hDEADBEEF) begin
      mismatched++;
      $display("FAIL bypass_rs: got %h expected deadbeef", bus.rs_data);
    end
    compared++;
    if (bus.wb_data !== 32'hDEADBEEF) begin
      mismatched++;
      $display("FAIL bypass_wb_data: got %h expected deadbeef", bus.wb_data);
    end
    compared++;
    if (bus.rt_data !== 32'h0) begin
      mismatched++;
      $display("FAIL bypass_rt_other: got %h expected 00000000", bus.rt_data);
    end
    advance();
    bus.regwrite  = 1'b0;
    bus.ALUResult = 32'h0;
    #1;
    compared++;
    if (bus.rs_data !== 32'hDEADBEEF) begin
      mismatched++;
      $display("FAIL array_rs: got %h expected deadbeef", bus.rs_data);
    end
    compared++;
    if (bus.sb_error !== 1'b0) begin
      mismatched++;
      $display("FAIL bypass_sb_error: got %b expected 0", bus.sb_error);
    end
  endtask

  task automatic test_r0();
    set_idle();
    bus.regwrite  = 1'b1;
    bus.regdst    = 5'd0;
    bus.memtoreg  = 1'b1;
    bus.mem_read  = 32'h00001234;
    bus.ALUResult = 32'hFFFFFFFF;
    #1;
    compared++;
    if (bus.wb_data !== 32'h00001234) begin
      mismatched++;
      $display("FAIL r0_wb_data: got %h expected 00001234", bus.wb_data);
    end
    compared++;
    if (bus.rs_data !== 32'h0 || bus.rt_data !== 32'h0) begin
      mismatched++;
      $display("FAIL r0_read_before: got %h/%h expected 0/0", bus.rs_data, bus.rt_data);
    end
    advance();
    bus.regwrite = 1'b0;
    #1;
    compared++;
    if (bus.rs_data !== 32'h0) begin
      mismatched++;
      $display("FAIL r0_read_after: got %h expected 00000000", bus.rs_data);
    end
    compared++;
    if (bus.sb_error !== 1'b0) begin
      mismatched++;
      $display("FAIL r0_sb_error: got %b expected 0", bus.sb_error);
    end
  endtask

  task automatic test_raw_stall();
    issue_writer(5'd7);
    set_idle();
    bus.issue_valid = 1'b1;
    bus.use_rs      = 1'b1;
    bus.rs_addr     = 5'd7;
    for (int c = 0; c < 2; c++) begin
      #1;
      compared++;
      if (bus.stall !== 1'b1) begin
        mismatched++;
        $display("FAIL raw_stall[%0d]: got %b expected 1", c, bus.stall);
      end
      advance();
    end
    bus.regwrite  = 1'b1;
    bus.regdst    = 5'd7;
    bus.ALUResult = 32'h00000055;
    #1;
    compared++;
    if (bus.stall !== 1'b0) begin
      mismatched++;
      $display("FAIL raw_release_stall: got %b expected 0", bus.stall);
    end
    compared++;
    if (bus.rs_data !== 32'h00000055) begin
      mismatched++;
      $display("FAIL raw_release_data: got %h expected 00000055", bus.rs_data);
    end
    advance();
    bus.regwrite = 1'b0;
    #1;
    compared++;
    if (bus.stall !== 1'b0 || bus.rs_data !== 32'h00000055) begin
      mismatched++;
      $display("FAIL raw_after: got stall=%b data=%h expected stall=0 data=00000055", bus.stall, bus.rs_data);
    end
  endtask

  task automatic test_kill_wb();
    issue_writer(5'd3);
    issue_writer(5'd3);
    set_idle();
    bus.issue_valid = 1'b1;
    bus.use_rt      = 1'b1;
    bus.rt_addr     = 5'd3;
    bus.kill_valid  = 1'b1;
    bus.kill_dst    = 5'd3;
    #1;
    compared++;
    if (bus.stall !== 1'b1) begin
      mismatched++;
      $display("FAIL kill_only_stall: got %b expected 1", bus.stall);
    end
    bus.regwrite  = 1'b1;
    bus.regdst    = 5'd3;
    bus.ALUResult = 32'hA5A50003;
    #1;
    compared++;
    if (bus.stall !== 1'b0) begin
      mismatched++;
      $display("FAIL kill_wb_stall: got %b expected 0", bus.stall);
    end
    advance();
    bus.kill_valid = 1'b0;
    bus.regwrite   = 1'b0;
    #1;
    compared++;
    if (bus.stall !== 1'b0 || bus.rt_data !== 32'hA5A50003) begin
      mismatched++;
      $display("FAIL kill_wb_after: got stall=%b data=%h expected stall=0 data=a5a50003", bus.stall, bus.rt_data);
    end
    compared++;
    if (bus.sb_error !== 1'b0) begin
      mismatched++;
      $display("FAIL kill_wb_sb_error: got %b expected 0", bus.sb_error);
    end
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 3; k++) issue_writer(5'd11);
    set_idle();
    #1;
    compared++;
    if (bus.sb_error !== 1'b0) begin
      mismatched++;
      $display("FAIL overflow_at_max: got %b expected 0", bus.sb_error);
    end
    issue_writer(5'd11);
    set_idle();
    #1;
    compared++;
    if (bus.sb_error !== 1'b1) begin
      mismatched++;
      $display("FAIL overflow_flag: got %b expected 1", bus.sb_error);
    end
  endtask

  task automatic test_underflow_reset();
    set_idle();
    #1;
    reset = 1'b1;
    bus.issue_valid = 1'b1;
    bus.use_rs      = 1'b1;
    bus.rs_addr     = 5'd11;
    #1;
    compared++;
    if (bus.sb_error !== 1'b0 || bus.stall !== 1'b0) begin
      mismatched++;
      $display("FAIL async_reset_1: got sb_error=%b stall=%b expected 0/0", bus.sb_error, bus.stall);
    end
    model_reset();
    advance();
    reset = 1'b0;
    set_idle();
    bus.regwrite  = 1'b1;
    bus.regdst    = 5'd9;
    bus.ALUResult = 32'h00000099;
    #1;
    compared++;
    if (bus.sb_error !== 1'b0) begin
      mismatched++;
      $display("FAIL underflow_before: got %b expected 0", bus.sb_error);
    end
    advance();
    set_idle();
    bus.issue_valid = 1'b1;
    bus.use_rs      = 1'b1;
    bus.rs_addr     = 5'd9;
    #1;
    compared++;
    if (bus.sb_error !== 1'b1) begin
      mismatched++;
      $display("FAIL underflow_flag: got %b expected 1", bus.sb_error);
    end
    compared++;
    if (bus.stall !== 1'b0 || bus.rs_data !== 32'h00000099) begin
      mismatched++;
      $display("FAIL underflow_hold: got stall=%b data=%h expected stall=0 data=00000099", bus.stall, bus.rs_data);
    end
    repeat (2) advance();
    compared++;
    if (bus.sb_error !== 1'b1) begin
      mismatched++;
      $display("FAIL underflow_sticky: got %b expected 1", bus.sb_error);
    end
    issue_writer(5'd12);
    set_idle();
    bus.issue_valid = 1'b1;
    bus.use_rs      = 1'b1;
    bus.rs_addr     = 5'd12;
    bus.rt_addr     = 5'd9;
    #2;
    reset = 1'b1;
    #1;
    compared++;
    if (bus.sb_error !== 1'b0 || bus.stall !== 1'b0 || bus.rt_data !== 32'h0) begin
      mismatched++;
      $display("FAIL async_reset_2: got sb_error=%b stall=%b rt=%h expected 0/0/00000000",
               bus.sb_error, bus.stall, bus.rt_data);
    end
    model_reset();
    advance();
    reset = 1'b0;
    set_idle();
  endtask

  task automatic test_random();
    addr_t a;
    for (int c = 0; c < 600; c++) begin
      set_idle();
      a = addr_t'($urandom_range(0, 7));
      bus.regdst    = a;
      bus.regwrite  = ((mPend[a] > 0) && ($urandom_range(0, 1) == 1)) || ($urandom_range(0, 49) == 0);
      bus.memtoreg  = $urandom_range(0, 1) == 1;
      bus.ALUResult = $urandom;
      bus.mem_read  = $urandom;
      bus.rs_addr   = addr_t'($urandom_range(0, 7));
      bus.rt_addr   = addr_t'($urandom_range(0, 7));
      bus.use_rs    = $urandom_range(0, 1) == 1;
      bus.use_rt    = $urandom_range(0, 1) == 1;
      bus.issue_valid    = $urandom_range(0, 9) < 6;
      bus.issue_regwrite = $urandom_range(0, 9) < 7;
      bus.issue_dst      = addr_t'($urandom_range(0, 7));
      a = addr_t'($urandom_range(0, 7));
      bus.kill_dst   = a;
      bus.kill_valid = (mPend[a] > 0) && ($urandom_range(0, 7) == 0);
      #1;
      compared++;
      if (bus.rs_data !== m_read(bus.rs_addr)) begin
        mismatched++;
        $display("FAIL rand_rs[%0d]: got %h expected %h", c, bus.rs_data, m_read(bus.rs_addr));
      end
      compared++;
      if (bus.rt_data !== m_read(bus.rt_addr)) begin
        mismatched++;
        $display("FAIL rand_rt[%0d]: got %h expected %h", c, bus.rt_data, m_read(bus.rt_addr));
      end
      compared++;
      if (bus.wb_data !== m_wb()) begin
        mismatched++;
        $display("FAIL rand_wb_data[%0d]: got %h expected %h", c, bus.wb_data, m_wb());
      end
      compared++;
      if (bus.stall !== m_stall()) begin
        mismatched++;
        $display("FAIL rand_stall[%0d]: got %b expected %b", c, bus.stall, m_stall());
      end
      compared++;
      if (bus.sb_error !== mErr) begin
        mismatched++;
        $display("FAIL rand_sb_error[%0d]: got %b expected %b", c, bus.sb_error, mErr);
      end
      advance();
    end
    set_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_bypass();
    test_r0();
    test_raw_stall();
    test_kill_wb();
    test_overflow();
    test_underflow_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
